// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit add/subtract unit. One 4-bit slice per clock goes
// through a 4-bit carry-lookahead slice, and the carry is registered between slices.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - operands presented
//   in_ready  - operands accepted (IDLE and rst low)
//   a, b      - WIDTH-bit operands
//   cin       - carry-in for add; ignored for subtract
//   sub       - 0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid - result valid (DONE)
//   out_ready - consumer accepts result
//   sum       - registered WIDTH-bit result
//   cout      - carry out of MSB (for subtract, 1 means no borrow)
//   overflow  - two's-complement signed overflow
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Current slice and its carry-lookahead result.
  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_c, nib_sum;
  logic       nib_cout;

  always_comb begin
    nib_a = op_a_q[{idx_q, 2'b00} +: 4];
    nib_b = op_b_q[{idx_q, 2'b00} +: 4];
    nib_g = nib_a & nib_b;
    nib_p = nib_a ^ nib_b;
    nib_c[0] = carry_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_cout = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0]) | ((&nib_p) & carry_q);
    nib_sum  = nib_p ^ nib_c;
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = a;
          // Inversion covers the full width before slicing.
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = nib_cout;
          ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (nib_sum[3] != op_a_q[WIDTH-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come from the state register only; rst masks in_ready.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares every DONE cycle against the queue head, pops on handshake.
  logic prev_valid = 1'b0;
  logic ready_next = 1'b0;
  always @(negedge clk) begin
    if (ready_next && !rst) check("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
    ready_next = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!prev_valid) check("latency", cyc - exp_q[0].acc, 32'd4);
        check("sum", {16'b0, sum}, {16'b0, exp_q[0].s});
        check("cout", {31'b0, cout}, {31'b0, exp_q[0].c});
        check("overflow", {31'b0, overflow}, {31'b0, exp_q[0].o});
        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          ready_next = 1'b1;
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                       input logic tsub, input bit push, input logic [15:0] es,
                       input logic ec, input logic eo);
    exp_t e;
    bit   ok = 0;
    @(posedge clk) #1;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (push && ok) begin
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; sub = ~tsub;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("result_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors.
    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1, 16'h2201, 1'b0, 1'b0); wait_done();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0); wait_done();
    issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0); wait_done();
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0); wait_done();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1); wait_done();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1); wait_done();

    // Backpressure: hold DONE while inputs churn.
    out_ready = 1'b0;
    issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1, 16'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      in_valid = ~in_valid;
      a = 16'(i * 16'h1111 + 16'h0101);
      b = 16'(16'hF0F0 - i);
    end
    @(posedge clk) #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();

    // Abort mid-operation after the second nibble.
    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk) #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_sum", {16'b0, sum}, 32'd0);
    check("abort_cout", {31'b0, cout}, 32'd0);
    check("abort_overflow", {31'b0, overflow}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("abort_no_valid", {31'b0, out_valid}, 32'd0);

    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0); wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
